// File: rtl/can_pkg.sv
// Shared CAN CRC-15 constants, check-FSM state type and the single-bit LFSR step
// used by both the transmit generator and the receive checker.
package can_pkg;

  localparam int unsigned CAN_CRC_W     = 15;
  localparam int unsigned CAN_BIT_CNT_W = 4;
  localparam int unsigned CAN_ERR_CNT_W = 8;

  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_INIT = 15'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    RECV  = 2'd2,
    DELIM = 2'd3
  } crc_chk_state_e;

  typedef struct packed {
    logic crc_ok;
    logic crc_err;
    logic form_err;
  } crc_result_t;

  // One CRC-15 shift: feedback is the incoming bit xor the current MSB.
  function automatic logic [CAN_CRC_W-1:0] crc15_step(input logic [CAN_CRC_W-1:0] crc,
                                                      input logic                 bit_in);
    logic w_fb;
    w_fb = bit_in ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (w_fb ? CAN_CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc15_lfsr.sv
// CAN CRC-15 LFSR shared by TX and RX: optional reload to INIT, then step with
// the bit on the same cycle when enabled.
module crc15_lfsr
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] INIT = CAN_CRC_INIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic                 i_din,
  output logic [CAN_CRC_W-1:0] o_crc
);

  logic [CAN_CRC_W-1:0] r_crc;
  logic [CAN_CRC_W-1:0] w_base;

  assign w_base = i_load ? INIT : r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= INIT;
    end else if (i_en) begin
      r_crc <= crc15_step(w_base, i_din);
    end else if (i_load) begin
      r_crc <= INIT;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc_check.sv
// CAN 2.0 receive CRC checker: CRC over SOF..data, capture of the 15-bit CRC
// sequence, delimiter check. Define CRC_CHECK_ERR_CNT_EN to add err_cnt.
module crc_check
  import can_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din,
  input  logic                     din_vld,
  input  logic                     sof,
  input  logic                     crc_start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     crc_ok,
  output logic                     crc_err,
  output logic                     form_err,
  output logic [CAN_CRC_W-1:0]     calc_crc,
  output logic [CAN_CRC_W-1:0]     rx_crc
`ifdef CRC_CHECK_ERR_CNT_EN
  ,
  output logic [CAN_ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned CRC_W   = CAN_CRC_W;
  localparam int unsigned BCNT_W  = CAN_BIT_CNT_W;
  localparam logic [BCNT_W-1:0] CRC_LAST = BCNT_W'(CRC_W);

  crc_chk_state_e      r_state;
  crc_chk_state_e      w_state_nxt;
  logic [BCNT_W-1:0]   r_bit_cnt;
  logic [BCNT_W-1:0]   w_bit_cnt_nxt;
  logic                w_lfsr_en;
  logic                w_lfsr_load;
  logic                w_rx_shift;
  logic                w_check;
  logic                w_crc_mismatch;
  logic [CRC_W-1:0]    w_calc_crc;
  logic [CRC_W-1:0]    r_rx_crc;
  crc_result_t         r_result;
  logic                r_done;
  logic                r_busy;

  crc15_lfsr #(
    .INIT (CAN_CRC_INIT)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_lfsr_en),
    .i_load (w_lfsr_load),
    .i_din  (din),
    .o_crc  (w_calc_crc)
  );

  assign w_crc_mismatch = (w_calc_crc != r_rx_crc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Abort dominates everything; an SOF-qualified bit restarts from any state.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_lfsr_en     = 1'b0;
    w_lfsr_load   = 1'b0;
    w_rx_shift    = 1'b0;
    w_check       = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else if (din_vld && sof) begin
      w_lfsr_load = 1'b1;
      w_lfsr_en   = 1'b1;
      w_state_nxt = CALC;
    end else if (din_vld) begin
      case (r_state)
        CALC: begin
          if (crc_start) begin
            w_rx_shift    = 1'b1;
            w_bit_cnt_nxt = BCNT_W'(1);
            w_state_nxt   = RECV;
          end else begin
            w_lfsr_en = 1'b1;
          end
        end
        RECV: begin
          w_rx_shift    = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
          if (w_bit_cnt_nxt == CRC_LAST) begin
            w_state_nxt = DELIM;
          end
        end
        DELIM: begin
          w_check     = 1'b1;
          w_state_nxt = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  // Received CRC, verdict flags and the done/busy handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_crc <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= w_check;
      r_busy <= (w_state_nxt != IDLE);
      if (w_lfsr_load) begin
        r_rx_crc <= '0;
      end else if (w_rx_shift) begin
        r_rx_crc <= {r_rx_crc[CRC_W-2:0], din};
      end
      if (w_lfsr_load) begin
        r_result <= '0;
      end else if (w_check) begin
        r_result.crc_err  <= w_crc_mismatch;
        r_result.form_err <= ~din;
        r_result.crc_ok   <= ~w_crc_mismatch & din;
      end
    end
  end

`ifdef CRC_CHECK_ERR_CNT_EN
  logic [CAN_ERR_CNT_W-1:0] r_err_cnt;

  // Saturating count of failed checks; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_check && (w_crc_mismatch || !din) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CAN_ERR_CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign crc_ok   = r_result.crc_ok;
  assign crc_err  = r_result.crc_err;
  assign form_err = r_result.form_err;
  assign calc_crc = w_calc_crc;
  assign rx_crc   = r_rx_crc;

endmodule

// File: tb/tb_crc_check.sv
// Randomized self-checking bench for crc_check against a frame-level model that
// computes the CRC by polynomial long division.
module tb_crc_check;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic        din_vld;
  logic        sof;
  logic        crc_start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        form_err;
  logic [14:0] calc_crc;
  logic [14:0] rx_crc;
`ifdef CRC_CHECK_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int          total;
  int          bad;
  logic        chk_on;

  // model state
  logic        m_busy, m_done, m_ok, m_cerr, m_ferr;
  logic [14:0] m_calc, m_rx;
  logic [63:0] m_data;
  int          m_len;
  int          m_phase;
  int          m_n;
  logic [7:0]  m_cnt;

  crc_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .sof       (sof),
    .crc_start (crc_start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .form_err  (form_err),
    .calc_crc  (calc_crc),
    .rx_crc    (rx_crc)
`ifdef CRC_CHECK_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Remainder of M(x)*x^15 divided by G(x) = x^15 + 0x4599.
  function automatic logic [14:0] ref_crc(input logic [63:0] bits, input int n);
    logic [15:0] rem;
    rem = '0;
    for (int i = 0; i < n + 15; i++) begin
      rem = {rem[14:0], (i < n) ? bits[i] : 1'b0};
      if (rem[15]) rem = rem ^ 16'hC599;
    end
    return rem[14:0];
  endfunction

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_ok = 0; m_cerr = 0; m_ferr = 0;
    m_calc = '0; m_rx = '0; m_data = '0; m_len = 0; m_phase = 0; m_n = 0; m_cnt = '0;
  endtask

  // Outputs the DUT must show after a clock edge that sampled these inputs.
  task automatic m_step(input logic d, input logic v, input logic s, input logic c, input logic a);
    m_done = 0;
    if (a) begin
      if (m_phase != 0) begin
        m_phase = 0;
        m_busy  = 0;
      end
    end else if (v && s) begin
      m_data = '0; m_data[0] = d; m_len = 1;
      m_calc = ref_crc(m_data, m_len);
      m_rx = '0; m_ok = 0; m_cerr = 0; m_ferr = 0;
      m_phase = 1; m_busy = 1;
    end else if (v && m_phase == 1) begin
      if (c) begin
        m_rx = {m_rx[13:0], d}; m_n = 1; m_phase = 2;
      end else begin
        if (m_len < 64) begin
          m_data[m_len] = d;
          m_len++;
        end
        m_calc = ref_crc(m_data, m_len);
      end
    end else if (v && m_phase == 2) begin
      if (m_n < 15) begin
        m_rx = {m_rx[13:0], d}; m_n++;
      end else begin
        m_cerr = (m_calc != m_rx);
        m_ferr = !d;
        m_ok   = !m_cerr && !m_ferr;
        m_done = 1; m_busy = 0; m_phase = 0;
        if ((m_cerr || m_ferr) && m_cnt != 8'hFF) m_cnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("crc_ok", 32'(crc_ok), 32'(m_ok));
      chk("crc_err", 32'(crc_err), 32'(m_cerr));
      chk("form_err", 32'(form_err), 32'(m_ferr));
      chk("calc_crc", 32'(calc_crc), 32'(m_calc));
      chk("rx_crc", 32'(rx_crc), 32'(m_rx));
`ifdef CRC_CHECK_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
    end
  end

  task automatic tick(input logic d, input logic v, input logic s, input logic c, input logic a);
    @(posedge clk);
    #2;
    if (rst_n) m_step(din, din_vld, sof, crc_start, abort);
    din = d; din_vld = v; sof = s; crc_start = c; abort = a;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 0;
    m_reset();
    din = 0; din_vld = 0; sof = 0; crc_start = 0; abort = 0;
    @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  // kill_mode: 0 whole frame, 1 abort at position kill_at, 2 stop sending at kill_at.
  task automatic send_frame(input logic [63:0] bits, input int nb, input logic [14:0] crc,
                            input logic delim, input int maxgap, input int kill_mode,
                            input int kill_at);
    for (int p = 0; p < nb + 16; p++) begin
      logic b;
      logic c;
      int   ng;
      if (kill_mode != 0 && p == kill_at) begin
        if (kill_mode == 1) tick(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b1);
        return;
      end
      ng = $urandom_range(0, maxgap);
      repeat (ng) tick(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
      if (p < nb) b = bits[p];
      else if (p < nb + 15) b = crc[14 - (p - nb)];
      else b = delim;
      c = (p == nb) ? 1'b1 : ((p > nb) ? 1'($urandom) : 1'b0);
      tick(b, 1'b1, (p == 0), c, 1'b0);
    end
  endtask

  initial begin
    total = 0; bad = 0; chk_on = 0;
    rst_n = 1; din = 0; din_vld = 0; sof = 0; crc_start = 0; abort = 0;
    m_reset();
    #1 rst_n = 0;
    #1 chk_on = 1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_calc", 32'(calc_crc), 32'd0);
    chk("rst_rx", 32'(rx_crc), 32'd0);
    chk("pin_model_zero", 32'(ref_crc(64'h0, 19)), 32'h0000);
    chk("pin_model_one", 32'(ref_crc(64'h2, 2)), 32'h4599);

    // all-zero frame
    send_frame(64'h0, 19, 15'h0000, 1'b1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_ok", 32'(crc_ok), 32'd1);
    chk("zero_calc", 32'(calc_crc), 32'h0000);
    chk("zero_rx", 32'(rx_crc), 32'h0000);

    // single-one payload
    send_frame(64'h2, 2, 15'h4599, 1'b1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("one_calc", 32'(calc_crc), 32'h4599);
    chk("one_ok", 32'(crc_ok), 32'd1);
    chk("one_err", 32'(crc_err), 32'd0);

    // corrupt CRC LSB
    send_frame(64'h2, 2, 15'h4598, 1'b1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("bad_rx", 32'(rx_crc), 32'h4598);
    chk("bad_err", 32'(crc_err), 32'd1);
    chk("bad_ok", 32'(crc_ok), 32'd0);
    chk("bad_done", 32'(done), 32'd1);

    // dominant delimiter
    send_frame(64'h0, 19, 15'h0000, 1'b0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("delim_form", 32'(form_err), 32'd1);
    chk("delim_err", 32'(crc_err), 32'd0);
    chk("delim_ok", 32'(crc_ok), 32'd0);

    // abort after 7 CRC bits, then a normal frame
    send_frame(64'h0, 19, 15'h0000, 1'b1, 1, 1, 19 + 7);
    tick(0, 0, 0, 0, 0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'({crc_ok, crc_err, form_err}), 32'd0);
    send_frame(64'h2, 2, 15'h4599, 1'b1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("post_abort_ok", 32'(crc_ok), 32'd1);

    // back-to-back strobes, SOF restart during RECV
    send_frame(64'h0, 19, 15'h0000, 1'b1, 0, 2, 19 + 5);
    send_frame(64'h2, 2, 15'h4599, 1'b1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_ok", 32'(crc_ok), 32'd1);

`ifdef CRC_CHECK_ERR_CNT_EN
    reset_pulse();
    send_frame(64'h2, 2, 15'h4598, 1'b1, 0, 0, 0);
    send_frame(64'h0, 19, 15'h0000, 1'b0, 0, 0, 0);
    send_frame(64'h2, 2, 15'h0001, 1'b0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("err_cnt_three", 32'(err_cnt), 32'd3);
`endif

    // randomized frames
    for (int it = 0; it < 200; it++) begin
      logic [63:0] bits;
      int          nb;
      logic [14:0] crc;
      int          r;
      int          mode;
      nb   = $urandom_range(1, 40);
      bits = {$urandom, $urandom};
      crc  = ($urandom_range(0, 2) != 0) ? ref_crc(bits, nb) : 15'($urandom);
      r    = $urandom_range(0, 9);
      mode = (r < 1) ? 1 : ((r < 2) ? 2 : 0);
      send_frame(bits, nb, crc, ($urandom_range(0, 4) != 0), $urandom_range(0, 2),
                 mode, $urandom_range(0, nb + 15));
      if (it % 40 == 39) reset_pulse();
      repeat ($urandom_range(0, 2)) tick(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
    end

    repeat (4) tick(0, 0, 0, 0, 0);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
